arm_mem_arbiter: RTL and testbench

- Arbitrates a single-port, fixed-latency external SRAM between two requesters in the ARM pipeline: the Instruction Fetch stage (reads only) and the Memory stage (reads and writes).
- Sequences each SRAM access over WAIT_CYCLES cycles.
- Returns a one-cycle ready pulse to the granted requester; the pipeline freeze logic uses it to stall IF or the whole pipeline.
- Sits between the IF/MEM stages and the SRAM pins, inside the ARM top.

---
 rtl/arm_mem_arbiter.sv | 117 +++++++++++
 tb/tb_arm_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/arm_mem_arbiter.sv
// Two-requester arbiter (IF reads, MEM reads/writes) for a single-port, fixed-latency SRAM.
// Each access holds the SRAM for WAIT_CYCLES cycles, then pulses the winner's ready for one cycle.
module arm_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic              sram_oe
);

  localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic       {GRANT_IF, GRANT_MEM} grant_t;

  state_t           state;
  grant_t           grant;
  grant_t           last_grant;
  logic             op_write;
  logic [CNT_W-1:0] cnt;

  logic mem_pend;
  logic pick_mem;
  logic pick_write;

  // Word addressing drops the byte-offset bits of both requester addresses.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{if_addr[1:0], mem_addr[1:0]};

  // MEM wins unless IF is also waiting and MEM had the previous grant.
  // A simultaneous MEM read+write is treated as a write.
  always_comb begin
    mem_pend   = mem_rd_en | mem_wr_en;
    pick_mem   = mem_pend && !(if_req && (last_grant == GRANT_MEM));
    pick_write = pick_mem && mem_wr_en;
  end

  // NOTE: all state and outputs live in one clocked block with non-blocking
  // assignments, so every output is a flop and nothing reads a half-updated value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= GRANT_IF;
      last_grant <= GRANT_IF;
      op_write   <= 1'b0;
      cnt        <= '0;
      if_rdata   <= '0;
      if_ready   <= 1'b0;
      mem_rdata  <= '0;
      mem_ready  <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_ce    <= 1'b0;
      sram_we    <= 1'b0;
      sram_oe    <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_req || mem_pend) begin
            state      <= ACCESS;
            cnt        <= '0;
            grant      <= pick_mem ? GRANT_MEM : GRANT_IF;
            last_grant <= pick_mem ? GRANT_MEM : GRANT_IF;
            op_write   <= pick_write;
            sram_ce    <= 1'b1;
            sram_we    <= pick_write;
            sram_oe    <= !pick_write;
            sram_addr  <= pick_mem ? mem_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
            sram_wdata <= pick_write ? mem_wdata : '0;
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            state      <= DONE;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_oe    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            if (grant == GRANT_MEM) begin
              mem_ready <= 1'b1;
              if (!op_write) mem_rdata <= sram_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= sram_rdata;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Scoreboard bench for arm_mem_arbiter: completions are predicted when requests are
// driven and compared (port, cycle, read data) when a ready pulse appears.
module tb_arm_mem_arbiter;

  localparam int W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd_en = 1'b0;
  logic        mem_wr_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [29:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ce;
  logic        sram_we;
  logic        sram_oe;

  arm_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: unwritten words return a fixed pattern; data is only driven while ce&&oe.
  function automatic logic [31:0] init_word(input logic [9:0] a);
    return (a == 10'd4) ? 32'hE3A0_1005 : (32'hA500_0000 | {22'd0, a});
  endfunction

  logic [31:0] sram_mem [0:1023];
  bit          sram_wr  [0:1023];
  always @(posedge clk)
    if (sram_ce && sram_we) begin
      sram_mem[sram_addr[9:0]] <= sram_wdata;
      sram_wr[sram_addr[9:0]]  <= 1'b1;
    end
  assign sram_rdata = !(sram_ce && sram_oe) ? 32'h0BAD_0BAD :
                      sram_wr[sram_addr[9:0]] ? sram_mem[sram_addr[9:0]] :
                      init_word(sram_addr[9:0]);

  logic [31:0] ref_mem [0:1023];
  logic [31:0] last_if  = '0;
  logic [31:0] last_mem = '0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    bit          is_mem;
    int          cyc;
    logic [31:0] if_rd;
    logic [31:0] mem_rd;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (if_ready || mem_ready)) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", {62'd0, if_ready, mem_ready}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("ready_port", {62'd0, if_ready, mem_ready}, e.is_mem ? 64'd1 : 64'd2);
        check("ready_cycle", 64'(cyc), 64'(e.cyc));
        check("if_rdata", {32'd0, if_rdata}, {32'd0, e.if_rd});
        check("mem_rdata", {32'd0, mem_rdata}, {32'd0, e.mem_rd});
      end
    end
  end

  task automatic clear_reqs();
    if_req = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
  endtask

  // One transaction from an idle arbiter, with per-cycle checks of the SRAM pins.
  task automatic run_txn(input bit is_mem, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit drop);
    exp_t e;
    bit   seen;
    bit   any_ce;
    bit   is_wr;
    is_wr = is_mem && wr;
    @(posedge clk); #1;
    if (is_mem) begin
      mem_rd_en = rd; mem_wr_en = wr; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    if (is_wr)       ref_mem[addr[11:2]] = wdata;
    else if (is_mem) last_mem = ref_mem[addr[11:2]];
    else             last_if  = ref_mem[addr[11:2]];
    e.is_mem = is_mem; e.cyc = cyc + W + 1; e.if_rd = last_if; e.mem_rd = last_mem;
    sb.push_back(e);
    @(posedge clk); #1;
    if (drop) clear_reqs();
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      check("acc_ctrl", {61'd0, sram_ce, sram_we, sram_oe}, is_wr ? 64'd6 : 64'd5);
      check("acc_addr", {34'd0, sram_addr}, {34'd0, addr[31:2]});
      if (is_wr) check("acc_wdata", {32'd0, sram_wdata}, {32'd0, wdata});
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = is_mem ? mem_ready : if_ready;
    end
    if (!seen) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    clear_reqs();
    if (drop) begin
      any_ce = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        any_ce |= sram_ce;
      end
      check("no_regrant", {63'd0, any_ce}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    bit   stray;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(10'(i));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {61'd0, sram_ce, sram_we, sram_oe}, 64'd0);
    check("rst_sram_addr", {34'd0, sram_addr}, 64'd0);
    check("rst_sram_wdata", {32'd0, sram_wdata}, 64'd0);
    check("rst_ready", {62'd0, if_ready, mem_ready}, 64'd0);
    check("rst_rdata", {if_rdata, mem_rdata}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);   // IF read
    run_txn(1'b1, 1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0); // MEM write
    run_txn(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b0);   // MEM read back
    run_txn(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0); // rd+wr -> write
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0, 1'b0);   // IF reads it back

    // Contention from reset: MEM, IF, MEM, IF
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h20; mem_rd_en = 1'b1; mem_addr = 32'h30;
    n = cyc;
    last_if = '0; last_mem = '0;
    for (int i = 0; i < 4; i++) begin
      e.is_mem = (i % 2) == 0;
      e.cyc    = n + (W + 2) * i + W + 1;
      if (e.is_mem) last_mem = ref_mem[12];
      else          last_if  = ref_mem[8];
      e.if_rd  = last_if;
      e.mem_rd = last_mem;
      sb.push_back(e);
    end
    for (int k = 0; k < 60 && sb.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    check("contention_done", 64'(sb.size()), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    clear_reqs();

    // Reset in the 2nd ACCESS cycle of an IF read
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_reqs();
    last_if = '0; last_mem = '0;
    @(negedge clk);
    check("midrst_ctrl", {61'd0, sram_ce, sram_we, sram_oe}, 64'd0);
    check("midrst_sram_addr", {34'd0, sram_addr}, 64'd0);
    check("midrst_sram_wdata", {32'd0, sram_wdata}, 64'd0);
    check("midrst_ready", {62'd0, if_ready, mem_ready}, 64'd0);
    check("midrst_rdata", {if_rdata, mem_rdata}, 64'd0);
    stray = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      stray |= if_ready | mem_ready | sram_ce;
    end
    check("midrst_quiet", {63'd0, stray}, 64'd0);
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 1'b0);   // fresh request

    // Dropped request: IF deasserts in the 1st ACCESS cycle
    run_txn(1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b1);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
